// File: rtl/audio_line_streamer.sv
// audio_line_streamer: double-buffered storage-line to sample-stream serializer (AUDIO_STREAMER_LOOP_EN loops the run)
module audio_line_streamer #(
  parameter int LINE_W   = 512,
  parameter int SAMPLE_W = 16,
  parameter int INDEX_W  = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [INDEX_W-1:0]  last_index,
  output logic [INDEX_W-1:0]  output_index,
  input  logic [LINE_W-1:0]   data_out,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                sample_last,
  output logic                busy,
  output logic                done
);
  localparam int NS = LINE_W / SAMPLE_W;
  localparam int SW = $clog2(NS);
`ifdef AUDIO_STREAMER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;
  state_t state, state_d;
  logic [LINE_W-1:0] cur, nxt;
  logic cur_v, nxt_v, pend;
  logic [SW-1:0] sidx;
  logic [INDEX_W-1:0] fidx, lidx, cidx, nidx;
  logic xfer, wrap, swap, stall, fill_end, swap_end, issue;
  assign sample_valid = (state == STREAM || state == DRAIN) && cur_v;
  assign sample_out   = cur[sidx*SAMPLE_W +: SAMPLE_W];
  assign sample_last  = sample_valid && (&sidx) && cidx == lidx;
  assign xfer         = sample_valid && sample_ready;
  assign wrap         = xfer && (&sidx);
  // promote nxt either at the end of the current line or to recover from a stall
  assign swap         = state == STREAM && nxt_v && (wrap || !cur_v);
  assign stall        = state == STREAM && wrap && !nxt_v;
  assign fill_end     = !LOOP && lidx == '0;
  assign swap_end     = !LOOP && nidx == lidx;
  assign issue        = (state == FILL && !fill_end) || (swap && !swap_end);
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  // next-state logic; abort overrides everything
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = start ? FILL : IDLE;
      FILL:    state_d = fill_end ? DRAIN : STREAM;
      STREAM:  state_d = (swap && swap_end) ? DRAIN : STREAM;
      DRAIN:   state_d = wrap ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end
  // line buffers, fetch sequencing, sample counter and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output_index <= '0;
      fidx <= '0;
      lidx <= '0;
      cidx <= '0;
      nidx <= '0;
      cur <= '0;
      nxt <= '0;
      cur_v <= 1'b0;
      nxt_v <= 1'b0;
      pend <= 1'b0;
      sidx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (abort) begin
      cur_v <= 1'b0;
      nxt_v <= 1'b0;
      pend <= 1'b0;
      sidx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= state == DRAIN && wrap;
      if (state == IDLE && start) begin
        output_index <= '0;
        fidx <= (LOOP && last_index == '0) ? '0 : INDEX_W'(1);
        lidx <= last_index;
        busy <= 1'b1;
        sidx <= '0;
        cur_v <= 1'b0;
        nxt_v <= 1'b0;
        pend <= 1'b0;
      end
      if (state == FILL) begin
        cur <= data_out;
        cidx <= '0;
        cur_v <= 1'b1;
      end
      if (issue) begin
        output_index <= fidx;
        fidx <= (LOOP && fidx == lidx) ? '0 : fidx + 1'b1;
        pend <= 1'b1;
      end else if (pend) begin
        nxt <= data_out;
        nidx <= output_index;
        nxt_v <= 1'b1;
        pend <= 1'b0;
      end
      if (xfer) sidx <= sidx + 1'b1;
      if (swap) begin
        cur <= nxt;
        cidx <= nidx;
        cur_v <= 1'b1;
        nxt_v <= 1'b0;
      end
      if (stall) cur_v <= 1'b0;
      if (state == DRAIN && wrap) begin
        busy <= 1'b0;
        cur_v <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_audio_line_streamer.sv
// tb_audio_line_streamer: scoreboard bench for audio_line_streamer
module tb_audio_line_streamer;
  localparam int LW = 512;
  localparam int SW = 16;
  localparam int IW = 12;
  typedef struct packed {logic [15:0] s; logic l;} exp_t;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, sample_ready = 1;
  logic [IW-1:0] last_index = '0;
  logic [IW-1:0] output_index;
  logic [LW-1:0] data_out;
  logic [SW-1:0] sample_out;
  logic sample_valid, sample_last, busy, done;
  logic [15:0] key = '0;
  logic [3:0] pat = 4'b1001;
  logic hold = 0;
  logic [15:0] held = '0;
  bit bp = 0;
  int tests = 0, fails = 0, acc = 0, done_cnt = 0, busy_cnt = 0, cyc = 0, t0 = 0, ph = 0;
  exp_t q[$];
  exp_t e;

  audio_line_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .last_index(last_index),
    .output_index(output_index), .data_out(data_out), .sample_out(sample_out),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_last(sample_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // storage model: line i holds (32i+k)^key in sample slot k, read one cycle after the index changes
  always_comb for (int k = 0; k < 32; k++) data_out[k*16 +: 16] = 16'(32 * output_index + k) ^ key;

  initial forever begin
    @(posedge clk);
    #1;
    sample_ready = bp ? pat[ph % 4] : 1'b1;
    ph++;
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  // monitor: stability of held samples, then pop/compare on every handshake
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (hold && rst_n) begin
      chk("hold_valid", {31'b0, sample_valid}, 1);
      chk("hold_data", {16'b0, sample_out}, {16'b0, held});
    end
    hold = sample_valid && !sample_ready && !abort && rst_n;
    held = sample_out;
    if (sample_valid && sample_ready && !abort) begin
      acc++;
      if (q.size() == 0) chk("unexpected_sample", 1, 0);
      else begin
        e = q.pop_front();
        chk("sample", {16'b0, sample_out}, {16'b0, e.s});
        chk("last", {31'b0, sample_last}, {31'b0, e.l});
      end
    end
  end

  task automatic push_run(input int li, input int passes);
    exp_t x;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i <= li; i++)
        for (int k = 0; k < 32; k++) begin
          x.s = 16'(32 * i + k) ^ key;
          x.l = (i == li && k == 31);
          q.push_back(x);
        end
  endtask

  task automatic do_start(input int li);
    @(posedge clk);
    #1;
    last_index = IW'(li);
    start = 1;
    busy_cnt = 0;
    @(posedge clk);
    #1;
    start = 0;
    t0 = cyc;
    chk("busy_rise", {31'b0, busy}, 1);
    chk("idx_zero", {20'b0, output_index}, 0);
    chk("valid_early", {31'b0, sample_valid}, 0);
    @(posedge clk);
    #1;
    chk("first_valid", {31'b0, sample_valid}, 1);
  endtask

  task automatic wait_done(input int limit, output int edge_no);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < limit);
    chk("done_seen", {31'b0, done}, 1);
    edge_no = cyc - t0 + 1;
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_idx"}, {20'b0, output_index}, 0);
    chk({n, "_smp"}, {16'b0, sample_out}, 0);
    chk({n, "_vld"}, {31'b0, sample_valid}, 0);
    chk({n, "_lst"}, {31'b0, sample_last}, 0);
    chk({n, "_bsy"}, {31'b0, busy}, 0);
    chk({n, "_dne"}, {31'b0, done}, 0);
  endtask

  initial begin
    int ed, dc, a0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1;
`ifdef AUDIO_STREAMER_LOOP_EN
    key = 16'h0000;
    dc = done_cnt;
    push_run(1, 3);
    do_start(1);
    for (int n = 0; n < 400 && q.size() > 0; n++) @(posedge clk) #2;
    chk("loop_drained", q.size(), 0);
    chk("loop_busy", {31'b0, busy}, 1);
    chk("loop_no_done", done_cnt, dc);
    abort = 1;
    @(posedge clk);
    #1;
    abort = 0;
    q.delete();
    chk("loop_abort_busy", {31'b0, busy}, 0);
`else
    // single line
    push_run(0, 1);
    do_start(0);
    wait_done(100, ed);
    chk("single_done_edge", ed, 34);
    chk("single_busy_cycles", busy_cnt, 33);
    chk("single_idx_end", {20'b0, output_index}, 0);
    chk("single_drained", q.size(), 0);
    @(negedge clk);
    chk("done_pulse_width", {31'b0, done}, 0);
    // eight lines, high-bit pattern
    key = 16'hA5C3;
    push_run(7, 1);
    do_start(7);
    wait_done(400, ed);
    chk("multi_done_edge", ed, 258);
    chk("multi_busy_cycles", busy_cnt, 257);
    chk("multi_idx_end", {20'b0, output_index}, 7);
    chk("multi_drained", q.size(), 0);
    // backpressure
    key = 16'h0000;
    bp = 1;
    push_run(2, 1);
    do_start(2);
    wait_done(1000, ed);
    chk("bp_drained", q.size(), 0);
    bp = 0;
    // abort after 40 samples of a 4-line run
    push_run(3, 1);
    a0 = acc;
    do_start(3);
    for (int n = 0; n < 200 && acc - a0 < 40; n++) @(posedge clk) #2;
    chk("abort_reached_40", {31'b0, acc - a0 >= 40}, 1);
    dc = done_cnt;
    abort = 1;
    @(posedge clk);
    #1;
    abort = 0;
    q.delete();
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_valid", {31'b0, sample_valid}, 0);
    chk("abort_idx_hold", {20'b0, output_index}, 2);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, dc);
    chk("abort_idx_still", {20'b0, output_index}, 2);
    // start and abort together: abort wins
    start = 1;
    abort = 1;
    @(posedge clk);
    #1;
    start = 0;
    abort = 0;
    chk("start_abort_idle", {31'b0, busy}, 0);
    @(posedge clk);
    #1;
    chk("start_abort_novalid", {31'b0, sample_valid}, 0);
    push_run(0, 1);
    do_start(0);
    wait_done(100, ed);
    chk("restart_done_edge", ed, 34);
    // asynchronous reset during streaming
    push_run(2, 1);
    do_start(2);
    repeat (20) @(posedge clk);
    dc = done_cnt;
    #3;
    rst_n = 0;
    #1;
    chk_zero("async");
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1;
    chk("async_no_done", done_cnt, dc);
    push_run(0, 1);
    do_start(0);
    wait_done(100, ed);
    chk("post_reset_done_edge", ed, 34);
`endif
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/audio_line_streamer.md
# audio_line_streamer

Reads 512-bit audio lines from the audio storage RAM by driving its `output_index`, and serializes each line into 32 signed 16-bit samples on a valid/ready stream. Sits directly downstream of the storage block and feeds the sample-rate processing chain. Double-buffers lines so that back-to-back samples cross line boundaries with no bubbles.

## Interface
Parameters:
- `LINE_W`, 512, width of one storage line.
- `SAMPLE_W`, 16, width of one sample.
- `INDEX_W`, 12, width of the line index (4096 lines).

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle pulse; begins a run at line 0. Ignored while `busy`.
- `abort`  in  1  ends a run at the next edge; has priority over everything except reset.
- `last_index`  in  INDEX_W  final line of the run, inclusive. Sampled on `start`.
- `output_index`  out  INDEX_W  line address to storage, registered.
- `data_out`  in  LINE_W  line from storage; valid one cycle after `output_index` changes.
- `sample_out`  out  SAMPLE_W  current sample.
- `sample_valid`  out  1  `sample_out` is valid.
- `sample_ready`  in  1  downstream accepts the sample when high with `sample_valid`.
- `sample_last`  out  1  high with the final sample of the run.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse after the final sample handshake.

## Operation
- Sample k of a line (k = 0..31) is `data_out[16k+15:16k]`. Sample 0 is sent first.
- The block holds two line registers, `cur` and `nxt`, each with a valid flag. It also holds a 5-bit sample counter `sidx` and a fetch index `fidx`.
- States:
  - IDLE: Waits for `start`.
  - FILL: Loads the first line into `cur`.
  - STREAM: Emits samples from `cur`.
  - DRAIN: The last line is in `cur` and no more fetches are issued.
- IDLE to FILL on `start`:
  - `output_index` is set to 0, `fidx` to 1, and `last_index` is latched into `lidx`.
  - `busy` rises on the same edge.
- FILL:
  - On the next edge, `data_out` is captured into `cur`.
  - If `lidx` is 0, go to DRAIN. Otherwise drive `output_index` to 1 and go to STREAM.
- STREAM:
  - Each cycle after a new index is issued, `data_out` is captured into `nxt` and `nxt_v` is set.
  - The next index is issued only after `nxt` is consumed.
- Handshake: A sample transfers on an edge where `sample_valid` and `sample_ready` are both high. `sidx` then increments.
- When `sidx` is 31 and a transfer occurs:
  - If `nxt_v`: `cur` takes `nxt`, `nxt_v` clears, `sidx` wraps to 0, and the next fetch is issued.
  - If the line just moved into `cur` has index `lidx`, go to DRAIN.
  - If `nxt_v` is 0 (stall), `sample_valid` drops until `nxt` arrives.
- DRAIN:
  - `sample_last` is high when `sidx` is 31.
  - On that transfer: go to IDLE, pulse `done`, drop `busy`.
- `abort`:
  - Forces IDLE on the next edge and clears both valid flags and `sidx`.
  - `done` does not pulse.
  - `output_index` holds its value.
- `sample_valid` never deasserts without a transfer, except on `abort` or reset.
- `sample_out` is stable while it is valid and not yet accepted.

## Timing
- All outputs are 0 during and after reset: `output_index`, `sample_out`, `sample_valid`, `sample_last`, `busy`, `done`.
- `start` at edge T:
  - `output_index` is 0 after T.
  - `cur` is loaded at T+1.
  - `sample_valid` is first high after T+1, so the first sample is available 2 cycles after `start`.
- Throughput: 1 sample per cycle when `sample_ready` is held high. The prefetch has 31 cycles of slack, so line boundaries add no bubbles.
- A run of N = `lidx`+1 lines with `sample_ready` always high:
  - `done` pulses after 32N + 2 edges following `start`.
  - `busy` is high for 32N+1 cycles.
- `start` and `abort` on the same edge: `abort` wins and the block stays in IDLE.
- Reset asserted mid-run: asynchronous clear to the reset values above. No `done` pulse.

## Configuration
- `AUDIO_STREAMER_LOOP_EN` defined:
  - After line `lidx` is consumed, the block continues at line 0. `fidx` wraps `lidx`→0, and 4095→0 when `lidx` is 4095.
  - `sample_last` still pulses on each pass; `done` never pulses.
  - Only `abort` or reset ends the run.
- Not defined: the run ends after line `lidx` as described in Operation.

## Test plan
- Single line:
  - Stimulus: `last_index`=0, storage line 0 = samples 0..31, `sample_ready`=1.
  - Response: samples 0,1,…,31 on consecutive cycles, first valid 2 cycles after `start`; `sample_last` with 31; `done` 1 cycle later; `output_index` ends at 0.
- Full sweep:
  - Stimulus: `last_index`=4095, each line i filled with 32i..32i+31, `sample_ready`=1.
  - Response: 131072 contiguous samples with no gaps; `done` at edge 131074 after `start`.
- Backpressure:
  - Stimulus: `last_index`=2, `sample_ready` toggling 1,0,0,1 pattern.
  - Response: each sample held stable while unaccepted; order 0..95 preserved; no sample dropped or duplicated.
- Abort:
  - Stimulus: assert `abort` at sample 40 of a 4-line run.
  - Response: `busy` and `sample_valid` low next cycle; no `done`. A following `start` restarts at sample 0.
- Async reset:
  - Stimulus: `rst_n` dropped mid-cycle during STREAM.
  - Response: all outputs 0 immediately. First sample valid 2 cycles after the next `start`.
- Loop (with `AUDIO_STREAMER_LOOP_EN`):
  - Stimulus: `last_index`=1.
  - Response: sample sequence 0..63, 0..63, …; `sample_last` every 64th sample; no `done`.
